// File: rtl/mef1_input_cond.sv
// Input conditioning for the mef1 controller: five raw asynchronous lines are
// synchronised, debounced, and delivered as clean levels (g, s, rd) or rising-edge pulses (back, ev).
module mef1_input_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic g_raw,
    input  logic s_raw,
    input  logic rd_raw,
    input  logic back_raw,
    input  logic ev_raw,
    output logic g,
    output logic s,
    output logic rd,
    output logic back,
    output logic ev
);

    localparam int NCH = 5;

    // Channel order: 0=g, 1=s, 2=rd, 3=back, 4=ev. Level channels idle high, pulse channels idle low.
    localparam logic [NCH-1:0] RST_LVL = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   accept;
    logic [1:0]       pulse;
    logic [CNT_W-1:0] cnt [NCH];

    assign raw = {ev_raw, back_raw, rd_raw, s_raw, g_raw};

    // A channel accepts its new level on the edge where the last required mismatch is seen.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NCH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= RST_LVL;
            sync2  <= RST_LVL;
            stable <= RST_LVL;
            pulse  <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            // Pulse only on an accepted 0->1 change; a 1->0 acceptance leaves it low.
            pulse <= {accept[4] & sync2[4], accept[3] & sync2[3]};
        end
    end

    assign g    = stable[0];
    assign s    = stable[1];
    assign rd   = stable[2];
    assign back = pulse[0];
    assign ev   = pulse[1];

endmodule
